// File: rtl/alu_cmd_frame_decoder.sv
// Command frame parser feeding the ALU sequencing controller: collects
// sync/A/B/C0/C1/checksum bytes, validates them and hands a frame over with a one-cycle Enable.
//
// state  | meaning
// IDLE   | waiting for the sync byte; other bytes dropped silently
// GET_A  | expecting operand A
// GET_B  | expecting operand B
// GET_C0 | expecting config byte 0
// GET_C1 | expecting config byte 1
// GET_CS | expecting checksum (XOR of A, B, C0, C1)
// PEND   | frame validated, waiting for the controller to go idle
module alu_cmd_frame_decoder #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hAA,
  parameter int                    TIMEOUT    = 1000,
  parameter int                    CNT_WIDTH  = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  Ctrl_Busy,
  output logic [DATA_WIDTH-1:0] ALU_OperA,
  output logic [DATA_WIDTH-1:0] ALU_OperB,
  output logic [DATA_WIDTH-1:0] ALU_Config0,
  output logic [DATA_WIDTH-1:0] ALU_Config1,
  output logic                  Enable,
  output logic                  Frame_Err,
  output logic [1:0]            Err_Code
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    GET_C0 = 3'd3,
    GET_C1 = 3'd4,
    GET_CS = 3'd5,
    PEND   = 3'd6
  } state_t;

  localparam logic [1:0]           ERR_NONE     = 2'b00;
  localparam logic [1:0]           ERR_CHECKSUM = 2'b01;
  localparam logic [1:0]           ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0]           ERR_OVERRUN  = 2'b11;
  localparam logic [CNT_WIDTH-1:0] TO_LAST      = CNT_WIDTH'(TIMEOUT - 1);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] shd_a;
  logic [DATA_WIDTH-1:0] shd_b;
  logic [DATA_WIDTH-1:0] shd_c0;
  logic [DATA_WIDTH-1:0] shd_c1;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;

  logic       is_sync;
  logic       timeout_hit;
  logic       load_out;
  logic       err_set;
  logic [1:0] err_code_nxt;
  logic       acc_clr;
  logic       counting_nxt;

  assign is_sync = (RX_P_DATA == SYNC_BYTE);

  // A byte arriving on the terminal cycle takes priority over the timeout.
  assign timeout_hit = !RX_D_VLD && (cnt == TO_LAST);

  always_comb begin
    state_nxt    = state;
    load_out     = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = ERR_NONE;
    acc_clr      = 1'b0;
    case (state)
      IDLE: begin
        if (RX_D_VLD && is_sync) begin
          state_nxt = GET_A;
          acc_clr   = 1'b1;
        end
      end
      GET_A, GET_B, GET_C0, GET_C1: begin
        if (RX_D_VLD) begin
          case (state)
            GET_A:   state_nxt = GET_B;
            GET_B:   state_nxt = GET_C0;
            GET_C0:  state_nxt = GET_C1;
            default: state_nxt = GET_CS;
          endcase
        end else if (timeout_hit) begin
          state_nxt    = IDLE;
          err_set      = 1'b1;
          err_code_nxt = ERR_TIMEOUT;
        end
      end
      GET_CS: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA != acc) begin
            state_nxt    = IDLE;
            err_set      = 1'b1;
            err_code_nxt = ERR_CHECKSUM;
          end else if (!Ctrl_Busy) begin
            state_nxt = IDLE;
            load_out  = 1'b1;
          end else begin
            state_nxt = PEND;
          end
        end else if (timeout_hit) begin
          state_nxt    = IDLE;
          err_set      = 1'b1;
          err_code_nxt = ERR_TIMEOUT;
        end
      end
      PEND: begin
        if (!Ctrl_Busy) begin
          // Hand-off and a coincident byte are both honoured: the byte is seen by IDLE.
          load_out = 1'b1;
          if (RX_D_VLD && is_sync) begin
            state_nxt = GET_A;
            acc_clr   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (RX_D_VLD) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_OVERRUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    counting_nxt = (state_nxt == GET_A) || (state_nxt == GET_B) || (state_nxt == GET_C0) ||
                   (state_nxt == GET_C1) || (state_nxt == GET_CS);
    if (!counting_nxt || RX_D_VLD) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      shd_a       <= '0;
      shd_b       <= '0;
      shd_c0      <= '0;
      shd_c1      <= '0;
      acc         <= '0;
      cnt         <= '0;
      ALU_OperA   <= '0;
      ALU_OperB   <= '0;
      ALU_Config0 <= '0;
      ALU_Config1 <= '0;
      Enable      <= 1'b0;
      Frame_Err   <= 1'b0;
      Err_Code    <= ERR_NONE;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      Enable    <= load_out;
      Frame_Err <= err_set;
      Err_Code  <= err_code_nxt;

      if (acc_clr) begin
        acc <= '0;
      end else if (RX_D_VLD && (state == GET_A || state == GET_B ||
                                state == GET_C0 || state == GET_C1)) begin
        acc <= acc ^ RX_P_DATA;
      end

      if (err_set && err_code_nxt == ERR_TIMEOUT) begin
        shd_a  <= '0;
        shd_b  <= '0;
        shd_c0 <= '0;
        shd_c1 <= '0;
      end else if (RX_D_VLD) begin
        case (state)
          GET_A:   shd_a  <= RX_P_DATA;
          GET_B:   shd_b  <= RX_P_DATA;
          GET_C0:  shd_c0 <= RX_P_DATA;
          GET_C1:  shd_c1 <= RX_P_DATA;
          default: ;
        endcase
      end

      if (load_out) begin
        ALU_OperA   <= shd_a;
        ALU_OperB   <= shd_b;
        ALU_Config0 <= shd_c0;
        ALU_Config1 <= shd_c1;
      end
    end
  end

endmodule
